// File: rtl/bit1_serial_master.sv
// Avalon-MM initiator that bit-bangs one byte, LSB first, through a 1-bit PIO slave,
// reads every bit back from the pin and reports the echoed byte plus a mismatch flag.
module bit1_serial_master #(
  parameter int          BIT_CYCLES = 4,
  parameter logic [2:0]  DATA_ADDR  = 3'd0,
  parameter logic [2:0]  DIR_ADDR   = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tx_byte,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_byte,
  output logic        mismatch,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    IDLE, DIR_ON, BIT_WR, BIT_WAIT, RD_ADDR, RD_CAP, DIR_OFF, DONE
  } state_t;

  state_t      state, state_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic [7:0]  tx_reg, tx_reg_next;
  logic [7:0]  rx_reg, rx_reg_next;
  logic        acc, acc_next;
  logic [7:0]  rx_byte_next;
  logic        mismatch_next;
  logic        busy_next, done_next, chipselect_next, write_n_next;
  logic [2:0]  address_next;
  logic [31:0] writedata_next;

  // Only bit 0 of the slave's read data carries the pin value.
  logic unused_readdata;
  assign unused_readdata = ^readdata[31:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      wait_cnt   <= '0;
      tx_reg     <= '0;
      rx_reg     <= '0;
      acc        <= 1'b0;
      rx_byte    <= '0;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= '0;
      writedata  <= '0;
    end else begin
      state      <= state_next;
      bit_idx    <= bit_idx_next;
      wait_cnt   <= wait_cnt_next;
      tx_reg     <= tx_reg_next;
      rx_reg     <= rx_reg_next;
      acc        <= acc_next;
      rx_byte    <= rx_byte_next;
      mismatch   <= mismatch_next;
      busy       <= busy_next;
      done       <= done_next;
      chipselect <= chipselect_next;
      write_n    <= write_n_next;
      address    <= address_next;
      writedata  <= writedata_next;
    end
  end

  always_comb begin
    state_next    = state;
    bit_idx_next  = bit_idx;
    wait_cnt_next = wait_cnt;
    tx_reg_next   = tx_reg;
    rx_reg_next   = rx_reg;
    acc_next      = acc;
    rx_byte_next  = rx_byte;
    mismatch_next = mismatch;

    case (state)
      IDLE: begin
        if (start) begin
          tx_reg_next  = tx_byte;
          rx_reg_next  = '0;
          bit_idx_next = '0;
          acc_next     = 1'b0;
          state_next   = DIR_ON;
        end
      end
      DIR_ON: state_next = BIT_WR;
      BIT_WR: begin
        wait_cnt_next = 16'(BIT_CYCLES);
        state_next    = BIT_WAIT;
      end
      BIT_WAIT: begin
        wait_cnt_next = wait_cnt - 16'd1;
        if (wait_cnt <= 16'd1) state_next = RD_ADDR;
      end
      RD_ADDR: state_next = RD_CAP;
      RD_CAP: begin
        rx_reg_next[bit_idx] = readdata[0];
        acc_next = acc | (readdata[0] ^ tx_reg[bit_idx]);
        if (bit_idx == 3'd7) begin
          state_next = DIR_OFF;
        end else begin
          bit_idx_next = bit_idx + 3'd1;
          state_next   = BIT_WR;
        end
      end
      DIR_OFF: begin
        rx_byte_next  = rx_reg;
        mismatch_next = acc;
        state_next    = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being entered.
    chipselect_next = 1'b0;
    write_n_next    = 1'b1;
    address_next    = '0;
    writedata_next  = '0;
    busy_next       = (state_next != IDLE);
    done_next       = (state_next == DONE);

    case (state_next)
      DIR_ON: begin
        chipselect_next = 1'b1;
        write_n_next    = 1'b0;
        address_next    = DIR_ADDR;
        writedata_next  = 32'd1;
      end
      BIT_WR: begin
        chipselect_next   = 1'b1;
        write_n_next      = 1'b0;
        address_next      = DATA_ADDR;
        writedata_next[0] = tx_reg_next[bit_idx_next];
      end
      RD_ADDR: begin
        chipselect_next = 1'b1;
        address_next    = DATA_ADDR;
      end
      DIR_OFF: begin
        chipselect_next = 1'b1;
        write_n_next    = 1'b0;
        address_next    = DIR_ADDR;
      end
      default: ;
    endcase
  end

endmodule
